// File: rtl/fix_to_float_pipe.sv
// fix_to_float_pipe: 3-stage fixed-point to {sign, exp, mant} converter with
// valid/ready backpressure. Stage 1 takes sign/magnitude, stage 2 finds the
// leading one, stage 3 normalises, optionally rounds, and registers the result.
module fix_to_float_pipe #(
  parameter int IN_W       = 15,
  parameter int MAN_W      = 10,
  parameter int EXP_W      = 7,
  parameter int EXP_OFFSET = 7,
  parameter int SIGNED     = 0,
  parameter int ROUND      = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_sign,
  output logic [EXP_W-1:0] o_out_exp,
  output logic [MAN_W-1:0] o_out_mant,
  output logic             o_out_zero
);
  localparam int               PW      = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [EXP_W-1:0] DEN_EXP = EXP_W'(MAN_W - 1 - EXP_OFFSET);
  localparam logic [PW-1:0]    P_TOP   = PW'(IN_W - 1);
  localparam logic [PW-1:0]    P_MSB   = PW'(MAN_W - 1);

  // ---------------- handshake ----------------
  // w_vld_pipe[0] is the incoming word, [k] is stage k's valid.
  logic [3:1] r_vld;
  logic [3:0] w_vld_pipe;
  logic [3:1] w_load;

  assign w_vld_pipe = {r_vld, i_in_valid};
  // A stage loads when it is empty or its contents move on this edge.
  assign w_load[3]  = ~r_vld[3] | i_out_ready;
  assign w_load[2]  = ~r_vld[2] | w_load[3];
  assign w_load[1]  = ~r_vld[1] | w_load[2];
  assign o_in_ready  = w_load[1];
  assign o_out_valid = w_vld_pipe[3];

  // Valid bits shift forward whenever the receiving stage loads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_vld <= '0;
    else
      for (int k = 1; k <= 3; k++)
        if (w_load[k]) r_vld[k] <= w_vld_pipe[k-1];
  end

  // ---------------- stage 1: sign / magnitude ----------------
  logic            w_neg;
  logic [IN_W-1:0] w_mag;
  logic            r1_sign, r1_zero;
  logic [IN_W-1:0] r1_mag;

  // The most negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign w_neg = (SIGNED != 0) && i_in_data[IN_W-1];
  assign w_mag = w_neg ? (~i_in_data + IN_W'(1)) : i_in_data;

  // Capture sign, magnitude and zero flag of the accepted word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_sign <= 1'b0;
      r1_mag  <= '0;
      r1_zero <= 1'b0;
    end else if (w_load[1] && w_vld_pipe[0]) begin
      r1_sign <= w_neg;
      r1_mag  <= w_mag;
      r1_zero <= (i_in_data == '0);
    end
  end

  // ---------------- stage 2: leading-one detect ----------------
  logic [PW-1:0]   w_p;
  logic [PW-1:0]   r2_p;
  logic [IN_W-1:0] r2_mag;
  logic            r2_sign, r2_zero;

  // Highest set bit wins; a zero magnitude reports index 0.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < IN_W; i++)
      if (r1_mag[i]) w_p = PW'(i);
  end

  // Carry the leading-one index forward with the magnitude.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r2_p    <= '0;
      r2_mag  <= '0;
      r2_sign <= 1'b0;
      r2_zero <= 1'b0;
    end else if (w_load[2] && w_vld_pipe[1]) begin
      r2_p    <= w_p;
      r2_mag  <= r1_mag;
      r2_sign <= r1_sign;
      r2_zero <= r1_zero;
    end
  end

  // ---------------- stage 3: normalise / round ----------------
  // w_win = {mag[p -: MAN_W], mag[p-MAN_W]}: the mantissa window plus the
  // first dropped bit (a shifted-in zero when nothing is dropped).
  logic [MAN_W:0]   w_win;
  logic             w_normal, w_rbit;
  logic [MAN_W:0]   w_sum;
  logic [EXP_W-1:0] w_exp_n;
  logic [MAN_W-1:0] w_mant;
  logic [EXP_W-1:0] w_exp;

  assign w_win    = (MAN_W+1)'(({r2_mag, 1'b0} << (P_TOP - r2_p)) >> (IN_W - MAN_W));
  assign w_normal = !r2_zero && (r2_p >= P_MSB);
  assign w_rbit   = (ROUND != 0) && w_normal && (r2_p > P_MSB) && w_win[0];
  assign w_sum    = {1'b0, w_win[MAN_W:1]} + {{MAN_W{1'b0}}, w_rbit};
  assign w_exp_n  = EXP_W'(r2_p) - EXP_W'(EXP_OFFSET);

  // Pick normal vs denormal result; a rounding carry renormalises, except at
  // the top bit where the exponent cannot grow, so the mantissa saturates.
  always_comb begin
    w_mant = r2_mag[MAN_W-1:0];
    w_exp  = DEN_EXP;
    if (w_normal) begin
      w_mant = w_sum[MAN_W-1:0];
      w_exp  = w_exp_n;
      if (w_sum[MAN_W]) begin
        if (r2_p == P_TOP) begin
          w_mant = '1;
        end else begin
          w_mant = w_sum[MAN_W:1];
          w_exp  = w_exp_n + EXP_W'(1);
        end
      end
    end
  end

  // Output register; holds while the downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_sign <= 1'b0;
      o_out_exp  <= '0;
      o_out_mant <= '0;
      o_out_zero <= 1'b0;
    end else if (w_load[3] && w_vld_pipe[2]) begin
      o_out_sign <= r2_sign & ~r2_zero;
      o_out_exp  <= w_exp;
      o_out_mant <= w_mant;
      o_out_zero <= r2_zero;
    end
  end
endmodule

// File: tb/tb_fix_to_float_pipe.sv
// Bench for fix_to_float_pipe: three instances (unsigned/truncate,
// unsigned/round, signed/truncate) share one stimulus stream; a queue-based
// arithmetic model predicts each result and a monitor checks every output.
module tb_fix_to_float_pipe;
  typedef struct packed {
    logic       sign;
    logic [6:0] exp;
    logic [9:0] mant;
    logic       zero;
  } res_t;
  typedef res_t [2:0] trio_t;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [14:0] in_data = '0;
  logic        ir[3], ov[3], osg[3], oz[3];
  logic [6:0]  oex[3];
  logic [9:0]  oma[3];
  int          total = 0, bad = 0, cyc = 0, acc = 0;
  bit          chk_lat = 1'b0;
  trio_t       qv[$];
  int          qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fix_to_float_pipe #(
      .IN_W(15), .MAN_W(10), .EXP_W(7), .EXP_OFFSET(7),
      .SIGNED((g == 2) ? 1 : 0), .ROUND((g == 1) ? 1 : 0)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(ir[g]),
      .i_in_data(in_data), .o_out_valid(ov[g]), .i_out_ready(out_ready),
      .o_out_sign(osg[g]), .o_out_exp(oex[g]), .o_out_mant(oma[g]), .o_out_zero(oz[g])
    );
  end

  function automatic res_t got(int k);
    return {osg[k], oex[k], oma[k], oz[k]};
  endfunction

  // Arithmetic model: magnitude as an integer, leading one by threshold search.
  function automatic res_t model(bit sg, bit rd, logic [14:0] d);
    res_t r;
    int mag, p, m, e;
    r.sign = sg && d[14];
    mag    = r.sign ? (32768 - int'(d)) : int'(d);
    r.zero = (mag == 0);
    p = -1;
    for (int b = 0; b < 15; b++) if (mag >= (1 << b)) p = b;
    if (p >= 9) begin
      m = mag >> (p - 9);
      e = p - 7;
      if (rd && p > 9) if (((mag >> (p - 10)) & 1) == 1) m = m + 1;
      if (m == 1024) begin
        if (p == 14) m = 1023;
        else begin m = 512; e = e + 1; end
      end
    end else begin
      m = mag;
      e = 2;
    end
    r.exp  = 7'(e);
    r.mant = 10'(m);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(logic [14:0] w);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = ir[0];
    end
    chk("send_accept", 32'(ok), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard, output hold under stall, instance agreement, latency.
  initial begin : mon
    trio_t t;
    int    c;
    bit    hold;
    res_t  held[3];
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qv.delete();
        qc.delete();
        hold = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'(0));
      end else begin
        for (int k = 1; k < 3; k++) chk($sformatf("valid_agree%0d", k), 32'(ov[k]), 32'(ov[0]));
        if (hold)
          for (int k = 0; k < 3; k++)
            chk($sformatf("hold%0d", k), 32'({ov[k], got(k)}), 32'({1'b1, held[k]}));
        if (ov[0] && out_ready) begin
          chk("out_expected", 32'(qv.size() > 0), 32'(1));
          if (qv.size() > 0) begin
            t = qv.pop_front();
            c = qc.pop_front();
            for (int k = 0; k < 3; k++) chk($sformatf("result%0d", k), 32'(got(k)), 32'(t[k]));
            if (chk_lat) chk("latency", 32'(cyc - c), 32'(3));
          end
        end
        hold = ov[0] && !out_ready;
        for (int k = 0; k < 3; k++) held[k] = got(k);
        if (in_valid && ir[0]) begin
          for (int k = 0; k < 3; k++) t[k] = model(k == 2, k == 1, in_data);
          qv.push_back(t);
          qc.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench stopped by watchdog");
  end

  logic [14:0] vecs[13] = '{15'h4000, 15'h0400, 15'h0155, 15'h0000, 15'h07FF, 15'h7FFF,
                            15'h0402, 15'h7C00, 15'h0001, 15'h03FF, 15'h0200, 15'h01FF, 15'h7E00};
  logic [14:0] bpv[5]   = '{15'h1234, 15'h0ABC, 15'h7FFF, 15'h0003, 15'h4001};

  initial begin : stim
    int nv;
    // hand-computed results that pin the model
    chk("pin_u_4000", 32'(model(0, 0, 15'h4000)), 32'({1'b0, 7'd7, 10'h200, 1'b0}));
    chk("pin_u_0400", 32'(model(0, 0, 15'h0400)), 32'({1'b0, 7'd3, 10'h200, 1'b0}));
    chk("pin_u_0155", 32'(model(0, 0, 15'h0155)), 32'({1'b0, 7'd2, 10'h155, 1'b0}));
    chk("pin_u_0000", 32'(model(0, 0, 15'h0000)), 32'({1'b0, 7'd2, 10'h000, 1'b1}));
    chk("pin_r_07FF", 32'(model(0, 1, 15'h07FF)), 32'({1'b0, 7'd4, 10'h200, 1'b0}));
    chk("pin_r_7FFF", 32'(model(0, 1, 15'h7FFF)), 32'({1'b0, 7'd7, 10'h3FF, 1'b0}));
    chk("pin_r_0402", 32'(model(0, 1, 15'h0402)), 32'({1'b0, 7'd3, 10'h201, 1'b0}));
    chk("pin_s_7C00", 32'(model(1, 0, 15'h7C00)), 32'({1'b1, 7'd3, 10'h200, 1'b0}));
    chk("pin_s_4000", 32'(model(1, 0, 15'h4000)), 32'({1'b1, 7'd7, 10'h200, 1'b0}));

    // reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_state%0d", k), 32'({ov[k], got(k)}), 32'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", 32'(ir[0]), 32'(1));

    // directed stream at full rate
    chk_lat = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    idle(8);

    // backpressure: only three words fit, then drain one per clock
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    acc       = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin send(bpv[i]); acc++; end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'(3));
        chk("bp_in_ready", 32'(ir[0]), 32'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        nv = 0;
        repeat (5) begin @(negedge clk); nv += int'(ov[0]); end
        chk("bp_drain_rate", 32'(nv), 32'(5));
      end
    join
    idle(8);

    // reset with three words in flight
    send(15'h0123); send(15'h2222); send(15'h7001);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("flush_valid%0d", k), 32'(ov[k]), 32'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); chk("no_stale", 32'(ov[0]), 32'(0)); end
    @(posedge clk); #1;
    chk_lat = 1'b1;
    send(15'h0801);
    idle(8);

    chk("queue_empty", 32'(qv.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fix_to_float_pipe.md
Name: fix_to_float_pipe

Overview:
- Parametrised, pipelined fixed-point to float converter. Successor to the 7-bit-exponent combinational converter in the LDPC min-sum datapath.
- Converts an unsigned or two's-complement fixed-point word to {sign, exponent, mantissa}, with optional round-half-up.
- Uses a 3-stage valid/ready pipeline so it sits between the LLR/message memories and the float check-node units at full clock rate, with backpressure.

Parameters:
- IN_W, 15: input word width.
- MAN_W, 10: mantissa width. Constraint: MAN_W <= IN_W.
- EXP_W, 7: exponent width. Constraint: IN_W-1-EXP_OFFSET+1 < 2^EXP_W.
- EXP_OFFSET, 7: exponent = leading-one index minus EXP_OFFSET. Constraint: EXP_OFFSET <= MAN_W-1.
- SIGNED, 0: 1 means in_data is two's complement; 0 means unsigned.
- ROUND, 0: 0 means truncate; 1 means round-half-up on the first dropped bit.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word this cycle.
- in_data  in  IN_W  fixed-point input.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  sign bit.
- out_exp  out  EXP_W  exponent.
- out_mant  out  MAN_W  mantissa (explicit leading one when normal).
- out_zero  out  1  input was zero.

Behaviour:
- Reset (async assert, sync-release handled outside): all stage valid bits clear, out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_zero=0. in_ready=1 one cycle after release.
- Transfer occurs when valid&&ready on the same edge. Throughput is 1 word/clk. Latency is 3 clk from input transfer to out_valid with out_ready held high.
- Stall rule: stage k loads when stage k is empty or stage k is advancing. in_ready = ~s1_valid | s1_advance, combinational from out_ready through the chain.
- While out_valid=1 and out_ready=0, all outputs hold stable. No word is dropped, duplicated or reordered.
- Reset asserted mid-stream flushes all in-flight words. No output after release until new input.
- Stage 1 (sign/magnitude):
  - SIGNED=1: sign = in_data[IN_W-1]; mag = |in_data|, IN_W-bit unsigned. -2^(IN_W-1) gives mag = 2^(IN_W-1) exactly.
  - SIGNED=0: sign=0, mag=in_data.
  - zero = (in_data==0).
- Stage 2 (leading-one detect): p = index of highest set bit of mag, priority from bit IN_W-1 down. Register p, mag, sign, zero.
- Stage 3 (normalise/round):
  - If p >= MAN_W-1: mant = mag[p -: MAN_W], exp = p-EXP_OFFSET.
  - Else (denormal, including zero): mant = mag[MAN_W-1:0], exp = MAN_W-1-EXP_OFFSET.
  - ROUND=1 and p > MAN_W-1: add mag[p-MAN_W] to mant.
  - On rounding carry-out: mant = 1 followed by zeros, exp = exp+1.
  - If that carry occurs at p = IN_W-1: saturate instead, mant = all ones, exp unchanged.
  - Denormal path never rounds.
- out_zero=1 gives mant=0, exp=MAN_W-1-EXP_OFFSET, sign=0.
- Defaults reproduce the existing 7-bit-exponent converter exactly when ROUND=0 and SIGNED=0.

Test Plan:
- Defaults, in_data=15'h4000 -> after 3 clk: sign=0, exp=7, mant=10'h200.
- Defaults, in_data=15'h0400 -> exp=3, mant=10'h200. in_data=15'h0155 -> exp=2, mant=10'h155. in_data=0 -> out_zero=1, exp=2, mant=0.
- ROUND=1: in_data=15'h07FF -> exp=4, mant=10'h200 (carry). in_data=15'h7FFF -> exp=7, mant=10'h3FF (saturate). in_data=15'h0402 -> exp=3, mant=10'h201.
- SIGNED=1: in_data=15'h7C00 (-1024) -> sign=1, exp=3, mant=10'h200. in_data=15'h4000 (-16384) -> sign=1, exp=7, mant=10'h200.
- Backpressure: send 5 consecutive words with out_ready=0 -> 3 accepted, then in_ready=0 and outputs stable. Raise out_ready -> all 5 emerge in order, one per clk.
- Reset mid-stream: assert rst_n=0 with 3 words in flight -> out_valid=0 immediately. After release, no stale output; a new word appears 3 clk after acceptance.
